fetch_unit: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a valid/ready request and valid response interface. It presents InstrF/PCF/PCPlus4F plus a valid flag to IF/ID, honours stalls from the hazard unit, and redirects on taken branches and jumps resolved in EX, discarding any in-flight response made stale by a redirect.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Contents:
//   fetch_state_t    : fetch FSM state encoding. FAULT is present only when
//                      FETCH_MISALIGN_CHECK_EN is defined.
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0), shown to IF/ID
//                      whenever no real instruction is available.
//   DEFAULT_RESET_PC : default program counter after reset.
//   pc_next_seq      : sequential successor of a PC, wrapping modulo 2^32.

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    KILL  = 3'd4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    FAULT = 3'd5
`endif
  } fetch_state_t;

  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction-fetch stage feeding the IF/ID register
//
// Owns the program counter and keeps at most one instruction-memory request
// in flight. Redirects from EX take effect on PCF the following cycle; any
// response belonging to a request made stale by a redirect is swallowed in
// KILL so it can never reach IF/ID.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a target with bits [1:0] != 0 parks the unit in
//               FAULT (fetch_misalign=1, no requests) until an aligned redirect.
//   undefined : redirect targets are word-aligned by clearing bits [1:0];
//               fetch_misalign is constant 0.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   stall_f             : hazard-unit stall, holds the presented instruction
//   pc_src_e            : redirect request from EX
//   pc_target_e[31:0]   : redirect target
//   imem_req_valid      : request valid (asserted only in REQ)
//   imem_req_ready      : memory accepts the request
//   imem_addr[31:0]     : request address, always equal to PCF
//   imem_rsp_valid      : response valid, one per accepted request
//   imem_rsp_data[31:0] : instruction word
//   InstrF[31:0]        : instruction to IF/ID (NOP unless fetch_valid)
//   PCF[31:0]           : current PC
//   PCPlus4F[31:0]      : PCF + 4, modulo 2^32
//   fetch_valid         : InstrF/PCF carry a real instruction
//   fetch_misalign      : misaligned-redirect fault indication

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        fetch_valid,
  output logic        fetch_misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  instr_q;

  // Value loaded into pc on a redirect.
  logic [31:0]  target;
  // Destination after a redirect when no request is left in flight.
  fetch_state_t resume_st;
  // Destination once the stale response has been swallowed in KILL.
  fetch_state_t kill_exit_st;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target       = pc_target_e;
  assign resume_st    = (pc_target_e[1:0] != 2'b00) ? FAULT : REQ;
  // pc already holds the most recent redirect target while in KILL, so its
  // low bits tell us whether that target was misaligned.
  assign kill_exit_st = (pc[1:0] != 2'b00) ? FAULT : REQ;
  assign fetch_misalign = (state == FAULT);
`else
  assign target       = pc_target_e & 32'hFFFF_FFFC;
  assign resume_st    = REQ;
  assign kill_exit_st = REQ;
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      case (state)
        IDLE: begin
          if (pc_src_e) begin
            pc    <= target;
            state <= resume_st;
          end else begin
            state <= REQ;
          end
        end

        REQ: begin
          if (pc_src_e) begin
            pc <= target;
            // An accepted request at the old address is now stale.
            if (imem_req_ready) state <= KILL;
            else                state <= resume_st;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (pc_src_e) begin
            pc <= target;
            // A response arriving with the redirect is dropped right here;
            // otherwise it is still on its way and must be drained in KILL.
            if (imem_rsp_valid) state <= resume_st;
            else                state <= KILL;
          end else if (imem_rsp_valid) begin
            instr_q <= imem_rsp_data;
            state   <= HOLD;
          end
        end

        HOLD: begin
          if (pc_src_e) begin
            pc    <= target;
            state <= resume_st;
          end else if (!stall_f) begin
            pc    <= pc_next_seq(pc);
            state <= REQ;
          end
        end

        KILL: begin
          if (pc_src_e) begin
            pc <= target;
            // Leave only once the stale response has actually arrived.
            if (imem_rsp_valid) state <= resume_st;
          end else if (imem_rsp_valid) begin
            state <= kill_exit_st;
          end
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        FAULT: begin
          if (pc_src_e) begin
            pc    <= target;
            state <= resume_st;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign PCF            = pc;
  assign PCPlus4F       = pc_next_seq(pc);
  assign fetch_valid    = (state == HOLD);
  assign InstrF         = (state == HOLD) ? instr_q : NOP_INSTR;

endmodule
